// File: rtl/mem_pkg.sv
// mem_pkg: ALUop codes, FSM states and access sizes shared by the memory access unit
package mem_pkg;
  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LH  = 5'b10001;
  localparam logic [4:0] OP_LW  = 5'b10010;
  localparam logic [4:0] OP_LBU = 5'b10100;
  localparam logic [4:0] OP_LHU = 5'b10101;
  localparam logic [4:0] OP_SB  = 5'b11000;
  localparam logic [4:0] OP_SH  = 5'b11001;
  localparam logic [4:0] OP_SW  = 5'b11010;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} size_e;
  function automatic logic is_mem_op(input logic [4:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction
  // op[1:0] is the access size, op[2] marks zero-extension, op[3] marks a store
  function automatic size_e op_size(input logic [1:0] sz);
    return size_e'(sz);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication, load extract/extend and misalign detect
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);
  logic [15:0] sh;
  always_comb begin
    sh = 16'(rdata_i >> {lane_i, 3'b000});
    be_o = size_i == WORD ? 4'hF : size_i == HALF ? 4'b0011 << lane_i : 4'b0001 << lane_i;
    wdata_o = size_i == WORD ? sdata_i : size_i == HALF ? {2{sdata_i[15:0]}} : {4{sdata_i[7:0]}};
    misalign_o = size_i == WORD ? |lane_i : size_i == HALF && lane_i[0];
    ldata_o = size_i == WORD ? rdata_i :
              size_i == HALF ? {{16{~unsigned_i & sh[15]}}, sh} : {{24{~unsigned_i & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs EX-stage loads/stores on a req/gnt/rvalid bus, stalling the core meanwhile
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  ALUop_i,
  input  logic [31:0] MemAddr_i,
  input  logic [31:0] StoreData_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  WriteDataNum_i,
  input  logic        WriteReg_i,
  output logic        WriteReg_o,
  output logic [4:0]  WriteDataNum_o,
  output logic [31:0] WriteData_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  state_e state_q, state_d;
  logic [3:0] op_q;
  logic [4:0] rd_q;
  logic [31:0] addr_q, sdata_q, data_q, data_d, wdata, ldata;
  logic we_q, idle, tmo, mis;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [2:0] op_s;
  logic [3:0] be;
  assign idle = state_q == IDLE;
  assign op_s = idle ? ALUop_i[2:0] : op_q[2:0];
  assign tmo = cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  // In IDLE the aligner looks at the live EX address to flag misalignment; afterwards at the captured one
  mem_lane_align u_align (
    .size_i(op_size(op_s[1:0])), .unsigned_i(op_s[2]),
    .lane_i(idle ? MemAddr_i[1:0] : addr_q[1:0]), .sdata_i(sdata_q), .rdata_i(mem_rdata_i),
    .be_o(be), .wdata_o(wdata), .ldata_o(ldata), .misalign_o(mis)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    data_d = data_q;
    WriteReg_o = 1'b0;
    WriteDataNum_o = '0;
    WriteData_o = '0;
    stall_o = 1'b0;
    misalign_o = 1'b0;
    bus_err_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = '0;
    mem_be_o = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_i && rst) begin
          if (!is_mem_op(ALUop_i)) begin
            WriteReg_o = WriteReg_i;
            WriteDataNum_o = WriteDataNum_i;
            WriteData_o = WriteData_i;
          end else if (mis) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            data_d = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (tmo) begin
          bus_err_o = 1'b1;
          state_d = IDLE;
        end else begin
          mem_req_o = 1'b1;
          mem_we_o = op_q[3];
          mem_addr_o = {addr_q[31:2], 2'b00};
          mem_be_o = be;
          mem_wdata_o = wdata;
          if (mem_gnt_i) begin
            state_d = op_q[3] || mem_rvalid_i ? DONE : WAIT;
            data_d = !op_q[3] && mem_rvalid_i ? ldata : data_q;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        bus_err_o = tmo;
        state_d = tmo ? IDLE : mem_rvalid_i ? DONE : WAIT;
        data_d = !tmo && mem_rvalid_i ? ldata : data_q;
      end
      default: begin
        WriteReg_o = we_q & ~op_q[3];
        WriteDataNum_o = rd_q;
        WriteData_o = data_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      sdata_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      if (idle && state_d == REQ) begin
        op_q <= ALUop_i[3:0];
        rd_q <= WriteDataNum_i;
        we_q <= WriteReg_i;
        addr_q <= MemAddr_i;
        sdata_q <= StoreData_i;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus with a queue scoreboard of writeback/misalign/bus-error events
module tb_mem_access_unit;
  import mem_pkg::*;
  localparam int EV_WB = 0, EV_MIS = 1, EV_ERR = 2;
  typedef struct {int kind; logic [4:0] rd; logic [31:0] data;} ev_t;
  typedef struct packed {logic [4:0] op; logic [31:0] a; logic [31:0] exp; logic [3:0] be;} ld_t;
  logic clk = 1'b0, rst, valid_i, WriteReg_i, WriteReg_o, stall_o, misalign_o, bus_err_o;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [4:0] ALUop_i, WriteDataNum_i, WriteDataNum_o;
  logic [31:0] MemAddr_i, StoreData_i, WriteData_i, WriteData_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_be_o;
  ev_t exp_q[$];
  int n_cmp = 0, n_fail = 0, req_cycles = 0, wb_cycles = 0;
  int gnt_wait = 0, rv_wait = 0, req_cnt = 0, pend = 0, err_at, st, w0, r0;
  bit no_gnt = 0, inj_rv = 0;
  logic [31:0] mem_word = '0, seen_addr, seen_wdata;
  logic [3:0] seen_be;
  logic seen_we, done_wr, req_at_err;
  ld_t lds[5];

  mem_access_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ALUop_i(ALUop_i), .MemAddr_i(MemAddr_i),
    .StoreData_i(StoreData_i), .WriteData_i(WriteData_i), .WriteDataNum_i(WriteDataNum_i),
    .WriteReg_i(WriteReg_i), .WriteReg_o(WriteReg_o), .WriteDataNum_o(WriteDataNum_o),
    .WriteData_o(WriteData_o), .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: grants after gnt_wait request cycles, returns read data rv_wait cycles after the grant
  always @(negedge clk) begin
    mem_gnt_i = 1'b0;
    mem_rvalid_i = inj_rv;
    if (!rst) begin
      pend = 0;
      req_cnt = 0;
    end else if (pend > 0) begin
      pend--;
      mem_rvalid_i = (pend == 0) | inj_rv;
    end else if (mem_req_o) begin
      if (!no_gnt && req_cnt == gnt_wait) begin
        mem_gnt_i = 1'b1;
        req_cnt = 0;
        if (!mem_we_o) begin
          if (rv_wait == 0) mem_rvalid_i = 1'b1;
          else pend = rv_wait;
        end
      end else req_cnt++;
    end else req_cnt = 0;
    mem_rdata_i = mem_rvalid_i ? mem_word : 32'hA5A5_5A5A;
  end

  always @(negedge clk) if (rst) begin
    int kind;
    ev_t e;
    if (mem_req_o) req_cycles++;
    if (WriteReg_o) wb_cycles++;
    if (WriteReg_o || misalign_o || bus_err_o) begin
      kind = WriteReg_o ? EV_WB : misalign_o ? EV_MIS : EV_ERR;
      if (exp_q.size() == 0) chk("spurious_event_kind", kind, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == EV_WB) begin
          chk("wb_rd", {27'd0, WriteDataNum_o}, {27'd0, e.rd});
          chk("wb_data", WriteData_o, e.data);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] wd, input logic [4:0] rd, output int n);
    bit ok = 0;
    @(posedge clk); #1;
    valid_i = 1'b1; ALUop_i = op; MemAddr_i = a; StoreData_i = sd;
    WriteData_i = wd; WriteDataNum_i = rd; WriteReg_i = 1'b1;
    n = 0;
    err_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req_o) begin
        seen_be = mem_be_o; seen_addr = mem_addr_o; seen_wdata = mem_wdata_o; seen_we = mem_we_o;
      end
      if (bus_err_o) begin err_at = n; req_at_err = mem_req_o; end
      if (!stall_o) begin done_wr = WriteReg_o; ok = 1; break; end
      n++;
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    if (!ok) chk("stall_timeout", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    lds[0] = '{OP_LB,  32'h201, 32'h0000_007F, 4'b0010};
    lds[1] = '{OP_LB,  32'h202, 32'hFFFF_FFFF, 4'b0100};
    lds[2] = '{OP_LBU, 32'h202, 32'h0000_00FF, 4'b0100};
    lds[3] = '{OP_LH,  32'h202, 32'hFFFF_80FF, 4'b1100};
    lds[4] = '{OP_LHU, 32'h200, 32'h0000_7F01, 4'b0011};
    rst = 1'b0; valid_i = 1'b1; ALUop_i = 5'b00000; MemAddr_i = '0; StoreData_i = '0;
    WriteData_i = 32'h55; WriteDataNum_i = 5'd1; WriteReg_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {31'd0, |{WriteReg_o, WriteDataNum_o, WriteData_o, stall_o, misalign_o, bus_err_o,
        mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}}, 32'd0);
    valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    exp_q.push_back(ev_t'{EV_WB, 5'd5, 32'h0000_1234});
    issue(5'b00000, 32'h0, 32'h0, 32'h1234, 5'd5, st);
    chk("add_stall", st, 0);
    gnt_wait = 1;
    issue(OP_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 5'd7, st);
    chk("sw_stall", st, 3);
    chk("sw_be", {28'd0, seen_be}, 32'hF);
    chk("sw_addr", seen_addr, 32'h100);
    chk("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
    chk("sw_we", {31'd0, seen_we}, 32'd1);
    chk("sw_done_wr", {31'd0, done_wr}, 32'd0);
    gnt_wait = 0;
    issue(OP_SB, 32'h103, 32'h1122_3344, 32'h0, 5'd7, st);
    chk("sb_be", {28'd0, seen_be}, 32'h8);
    chk("sb_wdata", seen_wdata, 32'h4444_4444);
    chk("sb_addr", seen_addr, 32'h100);
    chk("sb_stall", st, 2);
    issue(OP_SH, 32'h102, 32'hAABB_CCDD, 32'h0, 5'd7, st);
    chk("sh_be", {28'd0, seen_be}, 32'hC);
    chk("sh_wdata", seen_wdata, 32'hCCDD_CCDD);
    mem_word = 32'h80FF_7F01;
    rv_wait = 1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ev_t'{EV_WB, 5'(10 + i), lds[i].exp});
      issue(lds[i].op, lds[i].a, 32'h0, 32'h0, 5'(10 + i), st);
      chk("ld_be", {28'd0, seen_be}, {28'd0, lds[i].be});
      chk("ld_we", {31'd0, seen_we}, 32'd0);
      chk("ld_addr", seen_addr, 32'h200);
      chk("ld_stall", st, 3);
    end
    rv_wait = 0;
    w0 = wb_cycles;
    exp_q.push_back(ev_t'{EV_WB, 5'd9, 32'h80FF_7F01});
    issue(OP_LW, 32'h200, 32'h0, 32'h0, 5'd9, st);
    chk("lw_fast_stall", st, 2);
    chk("lw_wb_once", wb_cycles - w0, 1);
    r0 = req_cycles;
    exp_q.push_back(ev_t'{EV_MIS, 5'd0, 32'h0});
    issue(OP_LH, 32'h103, 32'h0, 32'h0, 5'd2, st);
    chk("mis_lh_stall", st, 0);
    chk("mis_lh_wr", {31'd0, done_wr}, 32'd0);
    exp_q.push_back(ev_t'{EV_MIS, 5'd0, 32'h0});
    issue(OP_SW, 32'h102, 32'h1, 32'h0, 5'd2, st);
    chk("mis_sw_stall", st, 0);
    chk("mis_no_req", req_cycles - r0, 0);
    no_gnt = 1;
    exp_q.push_back(ev_t'{EV_ERR, 5'd0, 32'h0});
    issue(OP_LW, 32'h200, 32'h0, 32'h0, 5'd6, st);
    chk("tmo_err_at", err_at, 4);
    chk("tmo_req_at_err", {31'd0, req_at_err}, 32'd0);
    chk("tmo_done_wr", {31'd0, done_wr}, 32'd0);
    no_gnt = 0;
    inj_rv = 1;
    @(negedge clk);
    chk("late_rv_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 inj_rv = 0;
    rv_wait = 20;
    w0 = wb_cycles;
    @(posedge clk); #1;
    valid_i = 1'b1; ALUop_i = OP_LW; MemAddr_i = 32'h200; WriteDataNum_i = 5'd3; WriteReg_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0;
    @(posedge clk); #1;
    chk("wait_stall", {31'd0, stall_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wr", {31'd0, WriteReg_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(ev_t'{EV_WB, 5'd4, 32'hCAFE_F00D});
    issue(5'b00000, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd4, st);
    chk("post_rst_add_stall", st, 0);
    repeat (25) @(posedge clk);
    chk("post_rst_wb_count", wb_cycles - w0, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
